sysid_uptime_slave: RTL
=======================

// Module: sysid_uptime_slave
// PURPOSE
//  Parametrised system-ID peripheral on the Avalon-MM control bus. Returns build ID, timestamp and version/capability words.
//  Adds a free-running, prescaled uptime counter with atomic 64-bit snapshot reads, a wrap flag and two scratch registers.
//  Software uses it to identify the loaded image, measure elapsed time and test bus access.
//  Reads are registered (fixed 1-cycle latency, readdatavalid).
// PARAMETERS
//  ID_VALUE      32'h678CE866  value returned at word 0 (system ID)
//  TIMESTAMP     32'd0         value returned at word 1 (build time, epoch seconds)
//  VERSION       16'h0002      block version, returned in word 2 [15:0]
//  UPTIME_WIDTH  64            uptime counter width, legal 33..64; unused upper bits read 0
//  PRESCALE      1             clocks per uptime increment, legal 1..65535
// PORTS
//  clock          in   1   system clock, all logic on rising edge
//  reset_n        in   1   asynchronous active-low reset
//  address        in   3   word address
//  read           in   1   read strobe, one cycle per access
//  write          in   1   write strobe, one cycle per access
//  writedata      in   32  write data
//  byteenable     in   4   byte lanes for writes
//  readdata       out  32  read data, valid when readdatavalid=1
//  readdatavalid  out  1   one-cycle pulse, 1 clock after read
// BEHAVIOUR
//  Map (word address):
//    0 ID RO
//    1 TIMESTAMP RO
//    2 CAPS RO = {UPTIME_WIDTH[7:0], 8'd2, VERSION}
//    3 CTRL: bit0 RUN (RW, reset 1); bit1 WRAP (RO sticky, W1C); bit2 CLR (WO, self-clearing, reads 0)
//    4 UPTIME_LO
//    5 UPTIME_HI
//    6 SCRATCH0 RW
//    7 SCRATCH1 RW
//  Reset: readdata=0, readdatavalid=0, uptime=0, prescaler=0, RUN=1, WRAP=0, snap/preload=0, scratch=0.
//  Read: read=1 in cycle N -> readdata registered at N+1 edge, readdatavalid=1 for exactly cycle N+1. readdata holds its value until the next read. Unused bits read 0.
//  Back-to-back reads are legal: one readdatavalid per read, in order.
//  Simultaneous read and write: read performed, write ignored.
//  Prescaler counts 0..PRESCALE-1 while RUN=1. Uptime increments on the clock where prescaler=PRESCALE-1. RUN=0 freezes both.
//  Wrap: increment from all-ones (UPTIME_WIDTH bits) -> 0 and WRAP=1. Wrap and W1C in the same cycle -> WRAP stays 1.
//  Atomic read: reading UPTIME_LO returns uptime[31:0] and, on the same edge, loads snap <= uptime[W-1:32].
//    Reading UPTIME_HI returns snap; it never returns the live count.
//  Write UPTIME_HI: byte-enabled write into a preload register; the counter is unchanged.
//  Write UPTIME_LO: uptime <= {preload, byte-merged writedata}, prescaler <= 0. The write takes priority over an increment in the same cycle.
//  CLR=1: uptime<=0, prescaler<=0. Priority: CLR > UPTIME_LO write > increment.
//  Scratch and CTRL writes honour byteenable. Writes to RO words (0-2) have no effect.
//  Reset asserted mid-access: outputs go to reset values immediately; a pending readdatavalid is dropped.
// TESTING
//  1. Reset release, read addr 0, 1, 2 back-to-back
//     -> readdatavalid on 3 consecutive cycles; data 32'h678CE866, 0, 32'h4002_0002
//  2. PRESCALE=4: clear, wait 40 clocks, read LO
//     -> value 10 (plus or minus 1 for access alignment); RUN=0 then 20 clocks -> value unchanged
//  3. Preload HI=0, LO=32'hFFFFFFFE; read LO at the carry cycle, then HI
//     -> {HI, LO} consistent (0/FFFFFFFF or 1/00000000), never 1/FFFFFFFF
//  4. UPTIME_WIDTH=64, preload all-ones, 1 increment
//     -> count 0, CTRL.WRAP=1; W1C clears it; W1C in the wrap cycle -> WRAP still 1
//  5. SCRATCH0 write 32'hA5A5A5A5 with be=4'b0101 over 0
//     -> reads 32'h00A500A5; read+write same cycle -> scratch unchanged
//  6. Assert reset_n low mid-read
//     -> readdatavalid=0 and readdata=0 asynchronously; CTRL reads 32'h1 after release

Source files
------------

// File: rtl/sysid_uptime_slave.sv
// Avalon-MM system-ID slave: fixed ID/timestamp/caps words, a prescaled uptime
// counter with atomic 64-bit snapshot reads, a sticky wrap flag and two scratch words.
module sysid_uptime_slave #(
  parameter logic [31:0] ID_VALUE     = 32'h678CE866,
  parameter logic [31:0] TIMESTAMP    = 32'd0,
  parameter logic [15:0] VERSION      = 16'h0002,
  parameter int unsigned UPTIME_WIDTH = 64,
  parameter int unsigned PRESCALE     = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        readdatavalid
);

  localparam int unsigned HIW = UPTIME_WIDTH - 32;
  localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);
  localparam logic [7:0]  CAPS_W  = 8'(UPTIME_WIDTH);
  localparam logic [UPTIME_WIDTH-1:0] UP_ONE = {{(UPTIME_WIDTH-1){1'b0}}, 1'b1};

  function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        r[8*i +: 8] = new_v[8*i +: 8];
      end else begin
        r[8*i +: 8] = old_v[8*i +: 8];
      end
    end
    return r;
  endfunction

  logic [UPTIME_WIDTH-1:0] uptime_q, uptime_d;
  logic [15:0] presc_q, presc_d;
  logic        run_q, run_d;
  logic        wrap_q, wrap_d;
  logic [31:0] snap_q, snap_d;
  logic [31:0] preload_q, preload_d;
  logic [31:0] scratch0_q, scratch0_d;
  logic [31:0] scratch1_q, scratch1_d;
  logic [31:0] readdata_q, readdata_d;
  logic        rvalid_q, rvalid_d;

  logic wr_en, tick, ctrl_wr, clr, lo_wr, wrap_evt;

  // Next-state logic: a read in the same cycle as a write suppresses the write.
  always_comb begin
    uptime_d   = uptime_q;
    presc_d    = presc_q;
    run_d      = run_q;
    snap_d     = snap_q;
    preload_d  = preload_q;
    scratch0_d = scratch0_q;
    scratch1_d = scratch1_q;
    readdata_d = readdata_q;
    rvalid_d   = read;

    wr_en    = write & ~read;
    tick     = run_q && (presc_q == PRE_MAX);
    ctrl_wr  = wr_en && (address == 3'd3) && byteenable[0];
    clr      = ctrl_wr && writedata[2];
    lo_wr    = wr_en && (address == 3'd4);
    wrap_evt = tick && (&uptime_q) && !clr && !lo_wr;

    if (ctrl_wr) begin
      run_d = writedata[0];
    end else begin
      run_d = run_q;
    end
    // A wrap on the same edge as a W1C wins, so no wrap event is ever lost.
    wrap_d = (wrap_q & ~(ctrl_wr & writedata[1])) | wrap_evt;

    if (run_q) begin
      presc_d = tick ? 16'd0 : presc_q + 16'd1;
    end else begin
      presc_d = presc_q;
    end

    if (clr) begin
      uptime_d = '0;
      presc_d  = 16'd0;
    end else if (lo_wr) begin
      uptime_d = {preload_q[HIW-1:0], be_merge(uptime_q[31:0], writedata, byteenable)};
      presc_d  = 16'd0;
    end else if (tick) begin
      uptime_d = uptime_q + UP_ONE;
    end else begin
      uptime_d = uptime_q;
    end

    if (wr_en && (address == 3'd5)) begin
      preload_d = be_merge(preload_q, writedata, byteenable);
    end else begin
      preload_d = preload_q;
    end
    if (wr_en && (address == 3'd6)) begin
      scratch0_d = be_merge(scratch0_q, writedata, byteenable);
    end else begin
      scratch0_d = scratch0_q;
    end
    if (wr_en && (address == 3'd7)) begin
      scratch1_d = be_merge(scratch1_q, writedata, byteenable);
    end else begin
      scratch1_d = scratch1_q;
    end

    if (read) begin
      case (address)
        3'd0: readdata_d = ID_VALUE;
        3'd1: readdata_d = TIMESTAMP;
        3'd2: readdata_d = {CAPS_W, 8'd2, VERSION};
        3'd3: readdata_d = {29'd0, 1'b0, wrap_q, run_q};
        3'd4: begin
          readdata_d = uptime_q[31:0];
          snap_d     = 32'(uptime_q[UPTIME_WIDTH-1:32]);
        end
        3'd5: readdata_d = snap_q;
        3'd6: readdata_d = scratch0_q;
        3'd7: readdata_d = scratch1_q;
        default: readdata_d = 32'd0;
      endcase
    end else begin
      readdata_d = readdata_q;
    end
  end

  // State and registered bus outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      uptime_q   <= '0;
      presc_q    <= 16'd0;
      run_q      <= 1'b1;
      wrap_q     <= 1'b0;
      snap_q     <= 32'd0;
      preload_q  <= 32'd0;
      scratch0_q <= 32'd0;
      scratch1_q <= 32'd0;
      readdata_q <= 32'd0;
      rvalid_q   <= 1'b0;
    end else begin
      uptime_q   <= uptime_d;
      presc_q    <= presc_d;
      run_q      <= run_d;
      wrap_q     <= wrap_d;
      snap_q     <= snap_d;
      preload_q  <= preload_d;
      scratch0_q <= scratch0_d;
      scratch1_q <= scratch1_d;
      readdata_q <= readdata_d;
      rvalid_q   <= rvalid_d;
    end
  end

  assign readdata      = readdata_q;
  assign readdatavalid = rvalid_q;

endmodule
